// File: rtl/count_seq_pkg.sv
// Shared definitions for count_sequencer: state encoding and job-register reset values.
package count_seq_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_LOAD   = S_LOAD,
    ST_SETTLE = S_SETTLE,
    ST_RUN    = S_RUN,
    ST_FINISH = S_FINISH
  } state_e;

  localparam int unsigned CNT_INIT_RST  = 0;
  localparam int unsigned CNT_FINAL_RST = 1;

endpackage

// File: rtl/seq_timeout_timer.sv
// RUN-state watchdog for count_sequencer; counts consecutive cycles with run_i high
// and flags the LIMIT-th such cycle.
module seq_timeout_timer #(
  parameter int LIMIT = 18
) (
  input  logic CLK,
  input  logic s_RST,
  input  logic run_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d     = run_i ? cnt_q + 1'b1 : '0;
    expired_o = run_i && (cnt_q == CW'(LIMIT - 1));
  end

  always_ff @(posedge CLK) begin
    if (s_RST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/count_sequencer.sv
// Job sequencer driving a loadable up/down counter through LOAD/SETTLE/RUN/FINISH.
// Optional RUN watchdog enabled by defining SEQ_TIMEOUT_EN.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int REG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 2**REG_WIDTH + 2
) (
  input  logic                 CLK,
  input  logic                 s_RST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [REG_WIDTH-1:0] req_init,
  input  logic [REG_WIDTH-1:0] req_final,
  input  logic                 req_up,
  output logic                 cnt_load,
  output logic                 cnt_count,
  output logic                 cnt_up,
  output logic [REG_WIDTH-1:0] cnt_init,
  output logic [REG_WIDTH-1:0] cnt_final,
  input  logic                 cnt_done,
  output logic                 seq_busy,
  output logic                 seq_done,
  output logic                 seq_err
);

  state_e                 state_q, state_d;
  logic [REG_WIDTH-1:0]   init_q, init_d;
  logic [REG_WIDTH-1:0]   final_q, final_d;
  logic                   up_q, up_d;
  logic                   err_q, err_d;
  logic                   fin, run_active, accept, bad_job, timeout;

  // The RUN cycle in which cnt_done first rises is itself the FINISH cycle, so the
  // job completes in |final-init|+3 cycles and counting stops exactly on final.
  assign fin        = (state_q == ST_FINISH) || ((state_q == ST_RUN) && cnt_done);
  assign run_active = (state_q == ST_RUN) && !cnt_done;
  assign req_ready  = (state_q == ST_IDLE) || fin;
  assign accept     = req_valid && req_ready;
  assign bad_job    = req_up ? (req_init > req_final) : (req_init < req_final);

`ifdef SEQ_TIMEOUT_EN
  seq_timeout_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .CLK      (CLK),
    .s_RST    (s_RST),
    .run_i    (run_active),
    .expired_o(timeout)
  );
`else
  // No watchdog in this build; the comparison is constant-false for any legal limit.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    final_d = final_q;
    up_d    = up_q;
    err_d   = 1'b0;
    if (accept) begin
      init_d  = req_init;
      final_d = req_final;
      up_d    = req_up;
    end
    if (req_ready) begin
      state_d = (accept && !bad_job) ? ST_LOAD : ST_IDLE;
      err_d   = accept && bad_job;
    end else begin
      case (state_q)
        ST_LOAD:   state_d = ST_SETTLE;
        ST_SETTLE: state_d = cnt_done ? ST_FINISH : ST_RUN;
        ST_RUN: begin
          if (timeout) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (s_RST) begin
      state_q <= ST_IDLE;
      init_q  <= REG_WIDTH'(CNT_INIT_RST);
      final_q <= REG_WIDTH'(CNT_FINAL_RST);
      up_q    <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      final_q <= final_d;
      up_q    <= up_d;
      err_q   <= err_d;
    end
  end

  assign cnt_load  = (state_q == ST_LOAD);
  assign cnt_count = run_active;
  assign cnt_up    = up_q;
  assign cnt_init  = init_q;
  assign cnt_final = final_q;
  assign seq_busy  = (state_q == ST_LOAD) || (state_q == ST_SETTLE) || run_active;
  assign seq_done  = fin;
  assign seq_err   = err_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a loadable up/down counter model on the cnt_* side.
module tb_count_sequencer;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         s_RST;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_init;
  logic [W-1:0] req_final;
  logic         req_up;
  logic         cnt_load;
  logic         cnt_count;
  logic         cnt_up;
  logic [W-1:0] cnt_init;
  logic [W-1:0] cnt_final;
  logic         cnt_done;
  logic         seq_busy;
  logic         seq_done;
  logic         seq_err;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  // Counter model: loads on cnt_load, steps on cnt_count, done when value equals final.
  logic [W-1:0] m_val;
  logic [W-1:0] m_fin;
  logic         tie_done = 1'b0;

  always_ff @(posedge CLK) begin
    if (s_RST) begin
      m_val <= '0;
      m_fin <= 4'd1;
    end else if (cnt_load) begin
      m_val <= cnt_init;
      m_fin <= cnt_final;
    end else if (cnt_count) begin
      m_val <= cnt_up ? m_val + 1'b1 : m_val - 1'b1;
    end
  end

  assign cnt_done = !tie_done && (m_val == m_fin);

  count_sequencer #(
    .REG_WIDTH     (W),
    .TIMEOUT_CYCLES(18)
  ) dut (
    .CLK      (CLK),
    .s_RST    (s_RST),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_init (req_init),
    .req_final(req_final),
    .req_up   (req_up),
    .cnt_load (cnt_load),
    .cnt_count(cnt_count),
    .cnt_up   (cnt_up),
    .cnt_init (cnt_init),
    .cnt_final(cnt_final),
    .cnt_done (cnt_done),
    .seq_busy (seq_busy),
    .seq_done (seq_done),
    .seq_err  (seq_err)
  );

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_ready"},  int'(req_ready), 1);
    chk({pfx, "_load"},   int'(cnt_load),  0);
    chk({pfx, "_count"},  int'(cnt_count), 0);
    chk({pfx, "_up"},     int'(cnt_up),    1);
    chk({pfx, "_init"},   int'(cnt_init),  0);
    chk({pfx, "_final"},  int'(cnt_final), 1);
    chk({pfx, "_busy"},   int'(seq_busy),  0);
    chk({pfx, "_done"},   int'(seq_done),  0);
    chk({pfx, "_err"},    int'(seq_err),   0);
  endtask

  // Offers one job from IDLE, then observes cycles 1..ncyc after the acceptance edge.
  task automatic run_job(input logic [W-1:0] i, input logic [W-1:0] f, input logic u,
                         input int ncyc, output int load_c, output int n_cnt,
                         output int done_c, output int err_c, output int n_busy,
                         output int bad_up, output int overlap);
    load_c = 0; n_cnt = 0; done_c = 0; err_c = 0; n_busy = 0; bad_up = 0; overlap = 0;
    req_init  = i;
    req_final = f;
    req_up    = u;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (cnt_load && load_c == 0) load_c = c;
      if (cnt_count) n_cnt++;
      if (seq_done && done_c == 0) done_c = c;
      if (seq_err && err_c == 0) err_c = c;
      if (seq_busy) n_busy++;
      if (seq_busy && cnt_up !== u) bad_up++;
      if (cnt_load && cnt_count) overlap++;
      tick();
    end
  endtask

  initial begin
    int lc, nc, dc, ec, nb, bu, ov;
    int l1, l2, d1, d2, b_init, b_up, nd, ne;

    s_RST     = 1'b1;
    req_valid = 1'b0;
    req_init  = '0;
    req_final = '0;
    req_up    = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    s_RST = 1'b0;
    tick();

    // Up job 2 -> 7
    run_job(4'd2, 4'd7, 1'b1, 12, lc, nc, dc, ec, nb, bu, ov);
    chk("up_load_cyc",  lc, 1);
    chk("up_counts",    nc, 5);
    chk("up_done_cyc",  dc, 8);
    chk("up_err",       ec, 0);
    chk("up_busy_cyc",  nb, 7);
    chk("up_dir",       bu, 0);
    chk("up_overlap",   ov, 0);
    chk("up_final_val", int'(m_val), 7);
    chk("up_ready_end", int'(req_ready), 1);

    // Down job 9 -> 3
    run_job(4'd9, 4'd3, 1'b0, 14, lc, nc, dc, ec, nb, bu, ov);
    chk("dn_load_cyc",  lc, 1);
    chk("dn_counts",    nc, 6);
    chk("dn_done_cyc",  dc, 9);
    chk("dn_busy_cyc",  nb, 8);
    chk("dn_dir",       bu, 0);
    chk("dn_overlap",   ov, 0);
    chk("dn_final_val", int'(m_val), 3);

    // Zero-length job 5 -> 5
    run_job(4'd5, 4'd5, 1'b1, 8, lc, nc, dc, ec, nb, bu, ov);
    chk("eq_load_cyc", lc, 1);
    chk("eq_counts",   nc, 0);
    chk("eq_done_cyc", dc, 3);
    chk("eq_busy_cyc", nb, 2);

    // Rejected jobs: wrong direction for the range
    run_job(4'd7, 4'd2, 1'b1, 6, lc, nc, dc, ec, nb, bu, ov);
    chk("rej_up_err",  ec, 1);
    chk("rej_up_load", lc, 0);
    chk("rej_up_done", dc, 0);
    chk("rej_up_busy", nb, 0);
    run_job(4'd2, 4'd7, 1'b0, 6, lc, nc, dc, ec, nb, bu, ov);
    chk("rej_dn_err",  ec, 1);
    chk("rej_dn_load", lc, 0);

    // Back-to-back: job A 1->3 up, job B 4->2 down offered continuously
    l1 = 0; l2 = 0; d1 = 0; d2 = 0; b_init = -1; b_up = -1;
    req_init  = 4'd1;
    req_final = 4'd3;
    req_up    = 1'b1;
    req_valid = 1'b1;
    tick();
    req_init  = 4'd4;
    req_final = 4'd2;
    req_up    = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 6) req_valid = 1'b0;
      if (cnt_load) begin
        if (l1 == 0) l1 = c;
        else if (l2 == 0) begin
          l2     = c;
          b_init = int'(cnt_init);
          b_up   = int'(cnt_up);
        end
      end
      if (seq_done) begin
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
      end
      tick();
    end
    chk("b2b_load_a", l1, 1);
    chk("b2b_done_a", d1, 5);
    chk("b2b_load_b", l2, 6);
    chk("b2b_done_b", d2, 10);
    chk("b2b_init_b", b_init, 4);
    chk("b2b_up_b",   b_up, 0);

    // Reset while in RUN
    req_init  = 4'd0;
    req_final = 4'd15;
    req_up    = 1'b1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_counting", int'(cnt_count), 1);
    s_RST = 1'b1;
    tick();
    check_reset_outputs("midrst");
    s_RST = 1'b0;
    nd = 0;
    ne = 0;
    for (int c = 0; c < 4; c++) begin
      if (seq_done) nd++;
      if (seq_err) ne++;
      tick();
    end
    chk("midrst_no_done", nd, 0);
    chk("midrst_no_err",  ne, 0);

`ifdef SEQ_TIMEOUT_EN
    // Counter never reports done: watchdog aborts after 18 RUN cycles
    tie_done = 1'b1;
    run_job(4'd0, 4'd10, 1'b1, 24, lc, nc, dc, ec, nb, bu, ov);
    chk("to_counts",   nc, 18);
    chk("to_err_cyc",  ec, 21);
    chk("to_done",     dc, 0);
    chk("to_ready",    int'(req_ready), 1);
    chk("to_busy_end", int'(seq_busy), 0);
    tie_done = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 4, giving the counter value width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2**REG_WIDTH+2, giving the RUN-state cycle limit (used only with SEQ_TIMEOUT_EN).
REQ-003 SHALL use reset s_RST, synchronous, active-high, and clock CLK.
REQ-004 Port CLK  in  1  clock; all logic on the rising edge.
REQ-005 Port s_RST  in  1  synchronous active-high reset.
REQ-006 Port req_valid  in  1  job request valid.
REQ-007 Port req_ready  out  1  sequencer can accept a job.
REQ-008 Port req_init  in  REG_WIDTH  job start value.
REQ-009 Port req_final  in  REG_WIDTH  job terminal value.
REQ-010 Port req_up  in  1  direction: 1 = up, 0 = down.
REQ-011 Port cnt_load  out  1  load strobe to the counter.
REQ-012 Port cnt_count  out  1  count enable to the counter.
REQ-013 Port cnt_up  out  1  counter direction.
REQ-014 Port cnt_init / cnt_final  out  REG_WIDTH each  values presented with cnt_load.
REQ-015 Port cnt_done  in  1  counter value equals its loaded final value.
REQ-016 Port seq_busy  out  1  a job is in progress.
REQ-017 Port seq_done  out  1  one-cycle pulse when a job completes normally.
REQ-018 Port seq_err  out  1  one-cycle pulse when a job is rejected or aborted.

Function
REQ-019 States SHALL be IDLE, LOAD, SETTLE, RUN and FINISH; a job is accepted when req_valid and req_ready are both 1.
REQ-020 req_ready SHALL be 1 only in IDLE and FINISH, so a new job can be accepted in the same cycle the previous one finishes.
REQ-021 On acceptance, the sequencer SHALL register init, final and up, then go to LOAD.
REQ-022 An accepted job with up=1 and init>final, or up=0 and init<final, SHALL NOT execute: seq_err pulses the next cycle and the state returns to IDLE (no wrap-around counting).
REQ-023 LOAD SHALL last exactly one cycle with cnt_load=1 and cnt_count=0; cnt_init, cnt_final and cnt_up SHALL hold the registered job values from LOAD through RUN.
REQ-024 cnt_load and cnt_count SHALL never be 1 in the same cycle.
REQ-025 SETTLE SHALL last one cycle with both strobes at 0, so that cnt_done reflects the newly loaded values.
REQ-026 If cnt_done=1 in SETTLE (init==final), the sequencer SHALL go directly to FINISH without asserting cnt_count.
REQ-027 Otherwise RUN SHALL drive cnt_count=1 and move to FINISH in the first cycle cnt_done=1; cnt_count SHALL be 0 in that cycle.
REQ-028 FINISH SHALL last one cycle with seq_done=1; it then goes to LOAD if a job was accepted that cycle, else to IDLE.
REQ-029 Job latency SHALL be |final-init| + 3 cycles from the acceptance edge to the seq_done cycle.
REQ-030 seq_busy SHALL be 1 in LOAD, SETTLE and RUN, and 0 otherwise.
REQ-031 req_* inputs SHALL be ignored while req_ready=0.

Reset
REQ-032 s_RST SHALL force IDLE from any state, including mid-job, and clear all job registers.
REQ-033 Reset values SHALL be req_ready=1, cnt_load=0, cnt_count=0, cnt_up=1, cnt_init=0, cnt_final=1, seq_busy=0, seq_done=0, seq_err=0.
REQ-034 No seq_done or seq_err pulse SHALL be emitted for a job aborted by reset.

Configuration
REQ-035 With macro SEQ_TIMEOUT_EN defined, a cycle counter SHALL run in RUN; if it reaches TIMEOUT_CYCLES without cnt_done, the sequencer SHALL drop cnt_count, pulse seq_err for one cycle and return to IDLE.
REQ-036 Without SEQ_TIMEOUT_EN, RUN SHALL wait indefinitely for cnt_done, and no timeout logic SHALL be synthesized.

Structure
REQ-037 Package count_seq_pkg SHALL hold the state enumeration typedef and the reset constants for cnt_init (0) and cnt_final (1).
REQ-038 The timeout counter SHALL be the sub-module seq_timeout_timer, instantiated only under SEQ_TIMEOUT_EN.

Verification
REQ-039 Accept init=2, final=7, up=1, paired with a counter model -> cnt_load in cycle 1, cnt_count for 5 cycles, seq_done in cycle 8.
REQ-040 Accept init=9, final=3, up=0 -> 6 down-counts, seq_done after 9 cycles, cnt_up=0 throughout.
REQ-041 Accept init=5, final=5 -> no cnt_count, seq_done 3 cycles after acceptance; init=7, final=2, up=1 -> seq_err pulse and no cnt_load.
REQ-042 Hold req_valid high with two back-to-back jobs -> second job accepted in FINISH, its cnt_load in the next cycle, no idle gap.
REQ-043 Assert s_RST in RUN -> all outputs at reset values the next cycle, and no seq_done or seq_err pulse.
REQ-044 SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=18, cnt_done tied to 0 -> seq_err after 18 RUN cycles, then IDLE with req_ready=1.
